// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the UART host command path.
// State encoding, SYNC default, command codes and timer width.
package uart_frame_pkg;

    localparam int TIMER_W = 16;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [7:0] CMD_MODE_SET   = 8'h10;
    localparam logic [7:0] CMD_MODE_GET   = 8'h20;
    localparam logic [7:0] CMD_SEND_START = 8'h30;
    localparam logic [7:0] CMD_SEND_STOP  = 8'h31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_CMD  = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } rx_state_t;

    function automatic logic [7:0] chk_step(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Clear/enable counter that saturates at all-ones and flags
// when the count reaches LIMIT while enabled.
module rx_timeout_counter
    import uart_frame_pkg::*;
#(
    parameter int           W     = TIMER_W,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/fsm_receive_data.sv
// Rebuilds [SYNC][CMD][payload LSB-first][chk] host frames from UART RX bytes.
// Define RX_CHECKSUM_EN to require a trailing XOR checksum byte.
module fsm_receive_data
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]         SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int                 NBYTES    = 2,
    parameter logic [TIMER_W-1:0] TIMEOUT   = 16'd10000,
    localparam int                DATA_W    = 8 * NBYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd,
    output logic [DATA_W-1:0] data,
    output logic              frame_err,
    output logic              busy
);

    rx_state_t         state, state_n;
    logic [1:0]        idx;
    logic [7:0]        cmd_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] data_new;
    logic              last;
    logic              expired;
    logic              cmd_ld, byte_ld, commit, err;

    assign busy = (state != IDLE);
    assign last = (idx == 2'(NBYTES - 1));

    rx_timeout_counter #(
        .W     (TIMER_W),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_ready || (state_n == IDLE)),
        .enable  (busy),
        .expired (expired)
    );

`ifdef RX_CHECKSUM_EN
    logic [7:0] chk;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chk <= '0;
        end else if (cmd_ld) begin
            chk <= rx_data;
        end else if (byte_ld) begin
            chk <= chk_step(chk, rx_data);
        end
    end

    assign data_new = data_sh;
`else
    // The final payload byte is committed straight from rx_data.
    always_comb begin
        data_new                 = data_sh;
        data_new[DATA_W-1 -: 8]  = rx_data;
    end
`endif

    always_comb begin
        state_n = state;
        cmd_ld  = 1'b0;
        byte_ld = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    state_n = GET_CMD;
                end
            end
            GET_CMD: begin
                if (rx_ready) begin
                    cmd_ld  = 1'b1;
                    state_n = GET_DATA;
                end else if (expired) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_ready) begin
                    byte_ld = 1'b1;
                    if (last) begin
`ifdef RX_CHECKSUM_EN
                        state_n = GET_CHK;
`else
                        commit  = 1'b1;
                        state_n = IDLE;
`endif
                    end
                end else if (expired) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
`ifdef RX_CHECKSUM_EN
            GET_CHK: begin
                if (rx_ready) begin
                    state_n = IDLE;
                    if (rx_data == chk) begin
                        commit = 1'b1;
                    end else begin
                        err    = 1'b1;
                    end
                end else if (expired) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            cmd_sh    <= '0;
            data_sh   <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_valid <= commit;
            frame_err <= err;
            if (cmd_ld) begin
                cmd_sh <= rx_data;
                idx    <= '0;
            end
            if (byte_ld) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == 2'(i)) begin
                        data_sh[8*i +: 8] <= rx_data;
                    end
                end
                idx <= idx + 1'b1;
            end
            if (commit) begin
                cmd  <= cmd_sh;
                data <= data_new;
            end
        end
    end

endmodule

// File: tb/tb_fsm_receive_data.sv
// Self-checking bench for fsm_receive_data: frame table plus
// hand-written timeout, boundary and reset sequences.
module tb_fsm_receive_data;

    localparam int TMO = 10000;
`ifdef RX_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  cmd;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          n_noise;
        logic [7:0]  noise0;
        logic [7:0]  noise1;
        logic [7:0]  c;
        logic [15:0] d;
        int          gap;
        bit          bad;
    } frm_t;

    exp_t        q[$];
    logic [7:0]  mdl_cmd  = 8'h00;
    logic [15:0] mdl_data = 16'h0000;

    fsm_receive_data dut (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .data      (data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid || frame_err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%0b err=%0b cmd=%h data=%h, required no pulse",
                         cmd_valid, frame_err, cmd, data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cmd_valid !== !e.is_err || frame_err !== e.is_err ||
                    cmd !== e.cmd || data !== e.data) begin
                    errors++;
                    $display("FAIL pulse got valid=%0b err=%0b cmd=%h data=%h, required valid=%0b err=%0b cmd=%h data=%h",
                             cmd_valid, frame_err, cmd, data,
                             !e.is_err, e.is_err, e.cmd, e.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        cyc();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b, required %b", name, got, req);
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (q.size() == 0) return;
            cyc();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout %0d pulses outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic expect_result(input logic [7:0] c, input logic [15:0] d, input bit good);
        exp_t e;
        if (good) begin
            mdl_cmd  = c;
            mdl_data = d;
        end
        e.is_err = !good;
        e.cmd    = mdl_cmd;
        e.data   = mdl_data;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d,
                              input int gap, input int stall, input bit bad);
        logic [7:0] ck;
        ck = c ^ d[7:0] ^ d[15:8];
        if (bad) ck = ~ck;
        send_byte(8'hA5);
        check_bit("busy_after_sync", busy, 1'b1);
        idle(gap);
        send_byte(c);
        idle(gap);
        send_byte(d[7:0]);
        idle(stall);
        if (CHK_EN) begin
            send_byte(d[15:8]);
            idle(gap);
            expect_result(c, d, !bad);
            send_byte(ck);
        end else begin
            expect_result(c, d, 1'b1);
            send_byte(d[15:8]);
        end
    endtask

    frm_t tbl[6];

    initial begin
        tbl[0] = '{0, 8'h00, 8'h00, 8'h10, 16'h1234, 1, 1'b0};
        tbl[1] = '{2, 8'h00, 8'hFF, 8'h20, 16'h0001, 0, 1'b0};
        tbl[2] = '{0, 8'h00, 8'h00, 8'hA5, 16'hA5A5, 2, 1'b0};
        tbl[3] = '{1, 8'h5A, 8'h00, 8'h7E, 16'hFFFF, 0, 1'b0};
        tbl[4] = '{0, 8'h00, 8'h00, 8'h31, 16'h8001, 3, 1'b1};
        tbl[5] = '{0, 8'h00, 8'h00, 8'h10, 16'h1234, 1, 1'b1};

        reset = 1'b0;
        idle(3);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_valid", cmd_valid, 1'b0);
        check_bit("rst_err", frame_err, 1'b0);
        check_bit("rst_zero", (cmd == 8'h00) && (data == 16'h0000), 1'b1);
        reset = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].n_noise > 0) begin
                send_byte(tbl[i].noise0);
                check_bit("noise0_busy", busy, 1'b0);
            end
            if (tbl[i].n_noise > 1) begin
                send_byte(tbl[i].noise1);
                check_bit("noise1_busy", busy, 1'b0);
            end
            send_frame(tbl[i].c, tbl[i].d, tbl[i].gap, tbl[i].gap, tbl[i].bad);
            drain(100);
            check_bit("frame_done_busy", busy, 1'b0);
            idle(2);
        end

        // back-to-back frames: SYNC arrives while cmd_valid is high
        send_frame(8'h11, 16'h2233, 0, 0, 1'b0);
        send_frame(8'h44, 16'h5566, 0, 0, 1'b0);
        drain(100);
        idle(2);

        // stalled frame times out
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h34);
        expect_result(8'h00, 16'h0000, 1'b0);
        drain(TMO + 100);
        check_bit("timeout_busy", busy, 1'b0);
        idle(3);

        // last data byte at timer == TIMEOUT-1 is accepted
        send_frame(8'h21, 16'h4321, 0, TMO - 1, 1'b0);
        drain(100);
        idle(2);

        // byte arriving with timer == TIMEOUT wins over the timeout
        send_frame(8'h22, 16'h8765, 0, TMO, 1'b0);
        drain(100);
        idle(2);

        // reset mid-frame drops the frame
        send_byte(8'hA5);
        send_byte(8'h10);
        reset = 1'b0;
        idle(2);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_zero", (cmd == 8'h00) && (data == 16'h0000), 1'b1);
        mdl_cmd  = 8'h00;
        mdl_data = 16'h0000;
        reset = 1'b1;
        idle(2);
        send_frame(8'h30, 16'hABCD, 0, 0, 1'b0);
        drain(100);
        idle(5);
        check_bit("final_queue_empty", q.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
